// File: rtl/demux1to8_32_buf.sv
// Registered 1-to-8 distributor: one valid/ready input stream fans out to eight
// single-entry output slots, each with its own valid/ready handshake.
`timescale 1ns/1ps
module demux1to8_32_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [2:0]           in_sel,
  input  logic                 in_bcast,
  output logic [7:0]           o_valid,
  input  logic [7:0]           o_ready,
  output logic [8*WIDTH-1:0]   o_data,
  output logic [CNT_W-1:0]     xfer_cnt
);

  logic [7:0]            valid_q, valid_d;
  logic [7:0][WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [7:0]            avail;
  logic [7:0]            wr_en;
  logic                  accept;

  // A slot draining this cycle can be refilled on the same edge.
  assign avail    = ~valid_q | o_ready;
  assign in_ready = in_bcast ? (&avail) : avail[in_sel];
  assign accept   = in_valid & in_ready;

  always_comb begin
    wr_en   = '0;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    for (int k = 0; k < 8; k++) begin
      wr_en[k]   = accept & (in_bcast | (in_sel == 3'(k)));
      valid_d[k] = wr_en[k] | (valid_q[k] & ~o_ready[k]);
      if (wr_en[k]) begin
        data_d[k] = in_data;
      end
    end
    if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_data   = data_q;
  assign xfer_cnt = cnt_q;

endmodule

// File: doc/demux1to8_32_buf.md
Name: demux1to8_32_buf

Overview:
- Registered 1-to-8 distributor for 32-bit words. It is the inverse of the team's 8-to-1 32-bit selector.
- Takes one valid/ready input stream with a 3-bit destination select (or a broadcast flag) and deposits each word into one of eight single-entry output slots.
- Each slot has its own valid/ready handshake.
- Used to fan a single producer (e.g. writeback/forwarding path) out to eight consumer ports.

Parameters:
WIDTH, 32, data width of input word and of each output slot.
CNT_W, 16, width of the accepted-transfer counter.

Ports:
clk  input  1  clock; all state changes on rising edge
rst_n  input  1  synchronous, active-low reset
in_valid  input  1  input word present
in_ready  output  1  block can accept input this cycle
in_data  input  WIDTH  input word
in_sel  input  3  destination slot 0..7
in_bcast  input  1  1 = write word to all eight slots (in_sel ignored)
o_valid  output  8  bit k = slot k holds an undelivered word
o_ready  input  8  bit k = consumer k takes slot k this cycle
o_data  output  8*WIDTH  slot k data at bits [k*WIDTH +: WIDTH]
xfer_cnt  output  CNT_W  number of accepted input transfers (broadcast counts once)

Behaviour:
- Reset: the single clock is clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
  - While rst_n=0 at an edge: o_valid=8'h00, every o_data slot=0, xfer_cnt=0.
  - Reset mid-operation discards all pending slot contents. No partial transfer survives.
- Slot availability: avail[k] = ~o_valid[k] | o_ready[k]. A slot being drained this cycle may be refilled in the same cycle.
- in_ready is combinational:
  - in_bcast=0: in_ready = avail[in_sel].
  - in_bcast=1: in_ready = &avail (all eight slots available).
  - Only in_ready depends combinationally on inputs. All other outputs are registered.
- Accept = in_valid & in_ready. On accept at edge N:
  - Unicast: slot[in_sel] <= in_data; o_valid[in_sel]=1 from cycle N+1.
  - Broadcast: all eight slots load in_data; o_valid=8'hFF from N+1.
  - xfer_cnt increments by 1. It wraps from all-ones to 0 without saturation or flag.
- Latency: 1 cycle from input accept to o_valid. Throughput is 1 word/cycle when the targeted consumers keep o_ready=1.
- Drain: when o_valid[k] & o_ready[k] and slot k is not written this edge, o_valid[k] clears at the edge.
  - o_data slot k keeps its last value after draining; only valid is cleared.
- Simultaneous drain + write to slot k: the new word is loaded and o_valid[k] stays 1. No bubble.
- o_ready[k] while o_valid[k]=0: ignored, no effect.
- Input protocol:
  - Once in_valid=1, the producer holds in_data/in_sel/in_bcast stable until accepted.
  - in_valid is not withdrawn before accept.
  - The block does not check these rules. A changed in_sel simply re-evaluates in_ready.
- Slots are independent. A stalled consumer k blocks only unicasts to k and all broadcasts. Words to other slots proceed.
- No reordering within a slot. Ordering across slots is not defined beyond accept order.
- in_valid=0: no state change except drains.

Test Plan:
- Reset: hold rst_n=0 two cycles with in_valid=1 -> o_valid=0, all o_data=0, xfer_cnt=0, no slot loaded. Release -> first accept occurs on the next edge.
- Unicast sweep, all o_ready=1: send 0xA0000000+k to in_sel=k for k=0..7 on consecutive cycles -> o_valid[k] pulses one cycle at N+1 with the matching data; in_ready stays 1; xfer_cnt=8.
- Backpressure: o_ready[3]=0, send 0x11111111 then 0x22222222 to slot 3 -> first word held, in_ready=0 on the second. Interleave 0x33333333 to slot 5, which is accepted. Raise o_ready[3] -> 0x22222222 loads in the same cycle the first drains, o_valid[3] continuous.
- Broadcast: o_valid[2]=1 pending with o_ready[2]=0, send bcast 0xDEADBEEF -> in_ready=0. Set o_ready[2]=1 -> accepted; next cycle o_valid=8'hFF, all slots 0xDEADBEEF; xfer_cnt +1.
- Counter wrap: preload via 65535 accepts -> xfer_cnt=0xFFFF; one more accept -> 0x0000.
- Reset mid-operation: slots 1, 4, 6 valid and undrained, pulse rst_n=0 one cycle -> o_valid=0, o_data=0, xfer_cnt=0 at that edge; no stale word appears afterward.
